// File: rtl/s_mem_arbiter_if.sv
// Bus between the RC4 sequencing FSMs, the S-array memory and the memory arbiter.
// The master side is the requesters plus the memory; the slave side is the arbiter.
interface s_mem_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        req_wr_en;
    logic [N_REQ*DATA_W-1:0] req_wr_data;
    logic [N_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_wr_en;
    logic [DATA_W-1:0]       mem_wr_data;
    logic [DATA_W-1:0]       mem_rd_data;
    logic [DATA_W-1:0]       rd_data;
    logic [N_REQ-1:0]        rd_valid;

    modport master (
        output req, req_addr, req_wr_en, req_wr_data, mem_rd_data,
        input  gnt, mem_addr, mem_wr_en, mem_wr_data, rd_data, rd_valid
    );

    modport slave (
        input  req, req_addr, req_wr_en, req_wr_data, mem_rd_data,
        output gnt, mem_addr, mem_wr_en, mem_wr_data, rd_data, rd_valid
    );
endinterface

// File: rtl/s_mem_arbiter.sv
// Round-robin, phase-granular arbiter for the single-port S-array memory.
// The owner keeps the port while its req is high; reads return a valid strobe RD_LAT cycles later.
module s_mem_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    s_mem_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, OWN, RELEASE} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [N_REQ-1:0]   vpipe_q [RD_LAT];
    logic [N_REQ-1:0]   vpipe_d [RD_LAT];

    logic               access;
    logic               found;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   idx;

    // Search starts one past the previous owner so nobody is granted twice while others wait.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = PTR_W'((int'(ptr_q) + k) % N_REQ);
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign access = (state_q == OWN) && gnt_q[owner_q] && bus.req[owner_q];

    always_comb begin
        bus.mem_addr    = '0;
        bus.mem_wr_data = '0;
        bus.mem_wr_en   = 1'b0;
        if (access) begin
            bus.mem_addr    = bus.req_addr[int'(owner_q)*ADDR_W +: ADDR_W];
            bus.mem_wr_data = bus.req_wr_data[int'(owner_q)*DATA_W +: DATA_W];
            bus.mem_wr_en   = bus.req_wr_en[owner_q];
        end
    end

    // Valid pipeline is independent of state so late read results still get their strobe.
    always_comb begin
        vpipe_d[0] = '0;
        if (access && !bus.req_wr_en[owner_q])
            vpipe_d[0] = N_REQ'(1) << owner_q;
        for (int i = 1; i < RD_LAT; i++)
            vpipe_d[i] = vpipe_q[i-1];
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = winner;
                    gnt_d   = N_REQ'(1) << winner;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (!bus.req[owner_q]) begin
                    gnt_d   = '0;
                    ptr_d   = owner_q;
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= PTR_W'(N_REQ - 1);
            owner_q <= '0;
            for (int i = 0; i < RD_LAT; i++)
                vpipe_q[i] <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            vpipe_q <= vpipe_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.rd_data  = bus.mem_rd_data;
    assign bus.rd_valid = vpipe_q[RD_LAT-1];
endmodule

// File: tb/tb_s_mem_arbiter.sv
// Directed bench for s_mem_arbiter with a 256x8 memory model of one-cycle read latency.
module tb_s_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    s_mem_arbiter_if #(.N_REQ(3), .ADDR_W(8), .DATA_W(8)) bus();

    s_mem_arbiter #(.N_REQ(3), .ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] mem_rd_q = 8'h00;
    always @(posedge clk) begin
        if (bus.mem_wr_en)
            mem[bus.mem_addr] <= bus.mem_wr_data;
        mem_rd_q <= mem[bus.mem_addr];
    end
    assign bus.mem_rd_data = mem_rd_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic r, input logic we,
                           input logic [7:0] a, input logic [7:0] d);
        bus.req[i]              = r;
        bus.req_wr_en[i]        = we;
        bus.req_addr[i*8 +: 8]  = a;
        bus.req_wr_data[i*8 +: 8] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output int who);
        int n;
        n = 0;
        while (bus.gnt == 3'b000 && n < 8) begin
            step();
            n++;
        end
        who = (bus.gnt == 3'b001) ? 0 : (bus.gnt == 3'b010) ? 1 : (bus.gnt == 3'b100) ? 2 : -1;
        if (n >= 8) check("gnt_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int wr_cnt, pre_cnt, bad, who;
        int rr_exp [4] = '{0, 1, 2, 0};

        bus.req = '0; bus.req_wr_en = '0; bus.req_addr = '0; bus.req_wr_data = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;

        #12;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        rst = 1'b0;
        step();

        // Requester 0 fills S[i]=i while requester 1 waits.
        set_req(0, 1'b1, 1'b1, 8'h00, 8'h00);
        set_req(1, 1'b1, 1'b1, 8'h10, 8'hAB);
        step();
        check("gnt_first", 32'(bus.gnt), 32'b001);
        wr_cnt = 0; pre_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            set_req(0, 1'b1, 1'b1, 8'(i), 8'(i));
            #1;
            if (bus.mem_wr_en && bus.mem_addr == 8'(i) && bus.mem_wr_data == 8'(i)) wr_cnt++;
            if (bus.gnt[1]) pre_cnt++;
            step();
        end
        check("wr_pulses", 32'(wr_cnt), 32'd256);
        check("no_preempt", 32'(pre_cnt), 32'd0);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("drop_wr_en", 32'(bus.mem_wr_en), 32'd0);
        step();
        check("release_gnt", 32'(bus.gnt), 32'b000);
        step();
        check("idle_gnt", 32'(bus.gnt), 32'b000);
        step();
        check("gnt_next", 32'(bus.gnt), 32'b010);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== 8'(i)) bad++;
        check("mem_fill", 32'(bad), 32'd0);

        // Owner 1 writes 0xAB to 0x10, then owner 2 reads it back.
        set_req(2, 1'b1, 1'b0, 8'h10, 8'h00);
        #1;
        check("wr_addr", 32'(bus.mem_addr), 32'h10);
        check("wr_data", 32'(bus.mem_wr_data), 32'hAB);
        step();
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        step(); step(); step();
        check("gnt_owner2", 32'(bus.gnt), 32'b100);
        check("rd_valid_early", 32'(bus.rd_valid), 32'b000);
        check("rd_addr", 32'(bus.mem_addr), 32'h10);
        step();
        set_req(2, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("rd_valid", 32'(bus.rd_valid), 32'b100);
        check("rd_data", 32'(bus.rd_data), 32'hAB);
        check("drop2_wr_en", 32'(bus.mem_wr_en), 32'd0);
        step();
        check("rel2_gnt", 32'(bus.gnt), 32'b000);
        check("rel2_wr_en", 32'(bus.mem_wr_en), 32'd0);
        check("rel2_rd_valid", 32'(bus.rd_valid), 32'b000);

        // Round robin under constant contention after a fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 8'h00, 8'h00);
        for (int k = 0; k < 4; k++) begin
            wait_gnt(who);
            check("rr_order", 32'(who), 32'(rr_exp[k]));
            if (k < 3) begin
                bus.req[who] = 1'b0;
                step();
                bus.req[who] = 1'b1;
                #1;
            end
        end

        // Owner 0 is reading; reset lands before the read's strobe.
        #2;
        check("pre_rst_access", 32'(bus.mem_addr == 8'h00 && bus.gnt == 3'b001), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_gnt", 32'(bus.gnt), 32'b000);
        check("midrst_wr_en", 32'(bus.mem_wr_en), 32'd0);
        check("midrst_rd_valid", 32'(bus.rd_valid), 32'b000);
        step();
        check("midrst_rd_valid_late", 32'(bus.rd_valid), 32'b000);
        rst = 1'b0;
        step();
        check("post_rst_gnt", 32'(bus.gnt), 32'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
